// File: rtl/rls_pkg.sv
// -----------------------------------------------------------------------------
// rls_pkg
// Shared definitions for the run-length serializer.
//   rls_state_t        : FSM state encoding (IDLE/ONES/ZERO/GAP)
//   RLS_CNT_W_DEFAULT  : default width of run_len and the run counter
// -----------------------------------------------------------------------------
package rls_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ONES = 2'b01,
      ZERO = 2'b10,
      GAP  = 2'b11
   } rls_state_t;

   localparam int RLS_CNT_W_DEFAULT = 4;

endpackage : rls_pkg

// File: rtl/rls_down_counter.sv
// -----------------------------------------------------------------------------
// rls_down_counter
// Loadable down counter with a gated decrement and an "equals one" flag.
// Used for the run counter and, with the idle-gap feature, the gap counter.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset (count -> 0)
//   i_load     : load i_load_val (has priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement by one (caller gates this with the bit tick)
//   o_is_one   : count currently equals 1 (last unit of the run/gap)
// -----------------------------------------------------------------------------
module rls_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_is_one
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         // Never wraps below zero, even if a caller decrements too often.
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_is_one = (r_cnt == W'(1));

endmodule : rls_down_counter

// File: rtl/run_length_serializer.sv
// -----------------------------------------------------------------------------
// run_length_serializer
// Serial transmitter for the run-terminated bit stream: each accepted frame
// is run_len ones followed by one terminating zero, one bit per bit_tick.
// Optional feature macro: RLS_IDLE_GAP_EN -- inserts GAP_LEN extra idle
// zeros after each frame (GAP_LEN+1 zeros of separation in total).
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset (drops any frame in flight)
//   bit_tick   : bit-rate strobe; the line advances only when high
//   run_len    : number of ones in the next frame (sampled at accept)
//   run_valid  : run_len is valid
//   run_ready  : combinational; accept when run_valid && run_ready
//   bit_out    : registered serial line bit
//   busy       : registered; high whenever the FSM is not IDLE
//   frame_done : registered one-cycle pulse after a terminating zero
// -----------------------------------------------------------------------------
module run_length_serializer
   import rls_pkg::*;
#(
   parameter int CNT_W   = RLS_CNT_W_DEFAULT,
   parameter int GAP_LEN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_tick,
   input  logic [CNT_W-1:0] run_len,
   input  logic             run_valid,
   output logic             run_ready,
   output logic             bit_out,
   output logic             busy,
   output logic             frame_done
);

   // A gap of zero idle bits is not a legal configuration.
   if (GAP_LEN < 1) begin : g_bad_gap_len
      $error("run_length_serializer: GAP_LEN must be >= 1");
   end

   rls_state_t r_state;
   rls_state_t w_state_nxt;
   logic       r_bit_out;
   logic       r_busy;
   logic       r_frame_done;
   logic       w_bit_nxt;
   logic       w_done_nxt;
   logic       w_ready;
   logic       w_accept;
   logic       w_run_load;
   logic       w_run_dec;
   logic       w_run_is_one;

   rls_down_counter #(
      .W (CNT_W)
   ) u_run_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_run_load),
      .i_load_val (run_len),
      .i_dec      (w_run_dec),
      .o_is_one   (w_run_is_one)
   );

`ifdef RLS_IDLE_GAP_EN
   localparam int GAP_W = (GAP_LEN < 2) ? 1 : $clog2(GAP_LEN + 1);

   logic w_gap_load;
   logic w_gap_dec;
   logic w_gap_is_one;

   rls_down_counter #(
      .W (GAP_W)
   ) u_gap_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_gap_load),
      .i_load_val (GAP_W'(GAP_LEN)),
      .i_dec      (w_gap_dec),
      .o_is_one   (w_gap_is_one)
   );
`endif

   // Ready is combinational so a frame can be taken on the very edge that
   // finishes the previous one (streaming with no idle bit in between).
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         IDLE:    w_ready = 1'b1;
`ifdef RLS_IDLE_GAP_EN
         ZERO:    w_ready = 1'b0;
         GAP:     w_ready = bit_tick & w_gap_is_one;
`else
         ZERO:    w_ready = bit_tick;
`endif
         default: w_ready = 1'b0;
      endcase
   end

   assign w_accept = run_valid & w_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit_out;
      w_done_nxt  = 1'b0;
      w_run_load  = 1'b0;
      w_run_dec   = 1'b0;
`ifdef RLS_IDLE_GAP_EN
      w_gap_load  = 1'b0;
      w_gap_dec   = 1'b0;
`endif

      case (r_state)
         IDLE: begin
            w_bit_nxt = 1'b0;
         end
         ONES: begin
            if (bit_tick) begin
               if (w_run_is_one) begin
                  w_state_nxt = ZERO;
                  w_bit_nxt   = 1'b0;
               end else begin
                  w_run_dec = 1'b1;
               end
            end
         end
         ZERO: begin
            w_bit_nxt = 1'b0;
            if (bit_tick) begin
               w_done_nxt = 1'b1;
`ifdef RLS_IDLE_GAP_EN
               w_state_nxt = GAP;
               w_gap_load  = 1'b1;
`else
               w_state_nxt = IDLE;
`endif
            end
         end
`ifdef RLS_IDLE_GAP_EN
         GAP: begin
            w_bit_nxt = 1'b0;
            if (bit_tick) begin
               if (w_gap_is_one) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_gap_dec = 1'b1;
               end
            end
         end
`endif
         default: begin
            // Unreachable encoding: recover to a quiet line.
            w_state_nxt = IDLE;
            w_bit_nxt   = 1'b0;
         end
      endcase

      // An accept overrides the exit chosen above; a zero-length frame is
      // a bare terminating zero.
      if (w_accept) begin
         if (run_len != '0) begin
            w_run_load  = 1'b1;
            w_state_nxt = ONES;
            w_bit_nxt   = 1'b1;
         end else begin
            w_state_nxt = ZERO;
            w_bit_nxt   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_bit_out    <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_out    <= w_bit_nxt;
         r_busy       <= (w_state_nxt != IDLE);
         r_frame_done <= w_done_nxt;
      end
   end

   assign run_ready  = w_ready;
   assign bit_out    = r_bit_out;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule : run_length_serializer

// File: tb/tb_run_length_serializer.sv
// -----------------------------------------------------------------------------
// tb_run_length_serializer
// Table-driven bench: each row gives the inputs for the next rising edge and
// the outputs expected just before that edge. Hand-written sequences cover
// asynchronous reset mid-frame and the maximum run length.
// -----------------------------------------------------------------------------
module tb_run_length_serializer;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             bit_tick;
   logic [CNT_W-1:0] run_len;
   logic             run_valid;
   logic             run_ready;
   logic             bit_out;
   logic             busy;
   logic             frame_done;

   int n_chk;
   int n_err;

   run_length_serializer #(
      .CNT_W   (CNT_W),
      .GAP_LEN (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bit_tick   (bit_tick),
      .run_len    (run_len),
      .run_valid  (run_valid),
      .run_ready  (run_ready),
      .bit_out    (bit_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string            nm;
      logic             tick;
      logic             valid;
      logic [CNT_W-1:0] len;
      logic             ready;
      logic             bo;
      logic             bsy;
      logic             done;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string nm, input logic t, input logic v, input int len,
                      input logic rdy, input logic bo, input logic bsy, input logic dn);
      vec_t r;
      r.nm    = nm;
      r.tick  = t;
      r.valid = v;
      r.len   = CNT_W'(len);
      r.ready = rdy;
      r.bo    = bo;
      r.bsy   = bsy;
      r.done  = dn;
      tbl.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Drive one row on the falling edge, then compare just after it.
   task automatic apply(input vec_t r);
      @(negedge clk);
      bit_tick  = r.tick;
      run_valid = r.valid;
      run_len   = r.len;
      #1;
      chk({r.nm, ".run_ready"},  32'(run_ready),  32'(r.ready));
      chk({r.nm, ".bit_out"},    32'(bit_out),    32'(r.bo));
      chk({r.nm, ".busy"},       32'(busy),       32'(r.bsy));
      chk({r.nm, ".frame_done"}, 32'(frame_done), 32'(r.done));
   endtask

   initial begin
      int ones;
      int guard;
      n_chk     = 0;
      n_err     = 0;
      reset     = 1'b1;
      bit_tick  = 1'b0;
      run_valid = 1'b0;
      run_len   = '0;

`ifndef RLS_IDLE_GAP_EN
      // Single frame, run_len=3, full rate: 1,1,1,0 then frame_done.
      //   name      tick val len  rdy bo bsy dn
      add("single0", 1, 1, 3,  1, 0, 0, 0);
      add("single1", 1, 0, 9,  0, 1, 1, 0);
      add("single2", 1, 0, 9,  0, 1, 1, 0);
      add("single3", 1, 0, 9,  0, 1, 1, 0);
      add("single4", 1, 0, 9,  1, 0, 1, 0);
      add("single5", 1, 0, 0,  1, 0, 0, 1);
      add("single6", 1, 0, 0,  1, 0, 0, 0);
      // Back-to-back 2 then 1 with run_valid held: 1,1,0,1,0.
      add("b2b0",    1, 1, 2,  1, 0, 0, 0);
      add("b2b1",    1, 1, 1,  0, 1, 1, 0);
      add("b2b2",    1, 1, 1,  0, 1, 1, 0);
      add("b2b3",    1, 1, 1,  1, 0, 1, 0);
      add("b2b4",    1, 0, 0,  0, 1, 1, 1);
      add("b2b5",    1, 0, 0,  1, 0, 1, 0);
      add("b2b6",    1, 0, 0,  1, 0, 0, 1);
      // Zero length: a single zero bit, one frame_done.
      add("zero0",   1, 1, 0,  1, 0, 0, 0);
      add("zero1",   1, 0, 0,  1, 0, 1, 0);
      add("zero2",   1, 0, 0,  1, 0, 0, 1);
      add("zero3",   1, 0, 0,  1, 0, 0, 0);
      // Tick every 3rd cycle, run_len=2; accept without a tick; run_len
      // changes after accept are ignored.
      add("gate0",   0, 1, 2,  1, 0, 0, 0);
      add("gate1",   0, 0, 7,  0, 1, 1, 0);
      add("gate2",   0, 0, 7,  0, 1, 1, 0);
      add("gate3",   1, 0, 7,  0, 1, 1, 0);
      add("gate4",   0, 0, 7,  0, 1, 1, 0);
      add("gate5",   0, 0, 7,  0, 1, 1, 0);
      add("gate6",   1, 0, 7,  0, 1, 1, 0);
      add("gate7",   0, 0, 7,  0, 0, 1, 0);
      add("gate8",   0, 0, 7,  0, 0, 1, 0);
      add("gate9",   1, 0, 7,  1, 0, 1, 0);
      add("gate10",  0, 0, 7,  1, 0, 0, 1);
      add("gate11",  0, 0, 7,  1, 0, 0, 0);
`else
      // Idle gap of 2: run_len=1 twice with run_valid held: 1,0,0,0,1,0.
      add("gap0",    1, 1, 1,  1, 0, 0, 0);
      add("gap1",    1, 1, 1,  0, 1, 1, 0);
      add("gap2",    1, 1, 1,  0, 0, 1, 0);
      add("gap3",    1, 1, 1,  0, 0, 1, 1);
      add("gap4",    1, 1, 1,  1, 0, 1, 0);
      add("gap5",    1, 0, 0,  0, 1, 1, 0);
      add("gap6",    1, 0, 0,  0, 0, 1, 0);
      add("gap7",    1, 0, 0,  0, 0, 1, 1);
      add("gap8",    1, 0, 0,  1, 0, 1, 0);
      add("gap9",    1, 0, 0,  1, 0, 0, 0);
`endif

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("reset.bit_out",    32'(bit_out),    32'd0);
      chk("reset.busy",       32'(busy),       32'd0);
      chk("reset.frame_done", 32'(frame_done), 32'd0);
      chk("reset.run_ready",  32'(run_ready),  32'd1);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) apply(tbl[i]);

      // Asynchronous reset after the 2nd one of a run_len=5 frame.
      @(negedge clk);
      bit_tick  = 1'b1;
      run_valid = 1'b1;
      run_len   = 4'd5;
      @(negedge clk);
      run_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("rstmid.pre_bit_out", 32'(bit_out), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("rstmid.bit_out", 32'(bit_out), 32'd0);
      chk("rstmid.busy",    32'(busy),    32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         chk("rstmid.no_frame_done", 32'(frame_done), 32'd0);
         chk("rstmid.idle_busy",     32'(busy),       32'd0);
      end

      // Maximum run length after the reset: exactly 15 ones.
      @(negedge clk);
      run_valid = 1'b1;
      run_len   = 4'd15;
      @(negedge clk);
      run_valid = 1'b0;
      run_len   = '0;
      ones  = 0;
      guard = 0;
      while (bit_out === 1'b1 && guard < 40) begin
         ones++;
         guard++;
         @(negedge clk);
      end
      chk("maxrun.ones", 32'(ones), 32'd15);
      guard = 0;
      while (busy !== 1'b0 && guard < 20) begin
         guard++;
         @(negedge clk);
      end
      chk("maxrun.busy_drops", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_run_length_serializer

// File: doc/run_length_serializer.md
Name: run_length_serializer

Overview:
- Serial transmitter for the run-terminated bit-stream protocol: each accepted frame is a run of N ones, then one terminating zero.
- The downstream Mealy run detector pulses its output on every terminating zero that follows one or more ones.
- Sits in front of that detector or a serial line.
- Accepts run lengths over a valid/ready handshake and emits one bit per bit_tick.

Parameters:
- CNT_W, 4: width of run_len and the internal run counter. Maximum run is 2^CNT_W-1.
- GAP_LEN, 2: number of idle zero bits inserted after each frame. Used only when RLS_IDLE_GAP_EN is defined; must be ≥1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- bit_tick  input  1  bit-rate strobe; the line advances only on edges where it is high
- run_len  input  CNT_W  number of ones in the next frame
- run_valid  input  1  run_len is valid
- run_ready  output  1  combinational; frame accepted at a clk edge when run_valid && run_ready
- bit_out  output  1  registered serial line bit
- busy  output  1  registered; high in any state other than IDLE
- frame_done  output  1  registered one-cycle pulse after a frame's terminating zero is consumed

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state=IDLE, cnt=0, bit_out=0, busy=0, frame_done=0.
- Reset is asynchronous and may occur mid-frame. It immediately forces bit_out=0. The frame in progress is dropped with no frame_done.
- States (2-bit encoding): IDLE=00, ONES=01, ZERO=10, GAP=11. GAP is unused without the macro. The unreachable encoding goes to IDLE with bit_out=0.
- IDLE: bit_out=0, run_ready=1.
  - Acceptance does not depend on bit_tick.
  - On accept with run_len≠0: cnt<=run_len, go to ONES, bit_out<=1.
  - On accept with run_len==0: go to ZERO, bit_out<=0. The frame is a bare zero, which the detector does not flag.
- ONES: run_ready=0.
  - On a bit_tick edge: if cnt==1, go to ZERO and bit_out<=0; otherwise cnt<=cnt-1.
  - Exactly run_len ticks of bit_out=1 are produced.
- ZERO: bit_out=0.
  - On a bit_tick edge: frame_done<=1 for one cycle, then exit ZERO.
  - run_ready = bit_tick in this state, which allows back-to-back streaming. An accept on that edge enters ONES or ZERO directly, exactly as from IDLE.
  - With no accept on that edge, go to IDLE.
- frame_done is 0 on every cycle other than the one after the ZERO tick.
- Minimum frame length on the line is run_len+1 ticks. bit_tick held high gives full rate.
- bit_tick low freezes state, cnt and bit_out. An IDLE accept still proceeds.
- run_len is sampled only at accept. Later changes are ignored.

Optional Feature:
- Macro: RLS_IDLE_GAP_EN.
- Defined:
  - ZERO's tick goes to GAP (gap counter=GAP_LEN) instead of IDLE. frame_done is still pulsed on the ZERO tick.
  - GAP holds bit_out=0 and decrements on each tick.
  - run_ready = bit_tick only when the gap counter is 1, and on that edge an accept is allowed. Otherwise go to IDLE.
  - run_ready=0 in ZERO.
  - Result: a guaranteed idle separation of GAP_LEN+1 zeros.
- Undefined: GAP is unreachable, and the behaviour is exactly as described above.

Decomposition:
- Shared package rls_pkg:
  - state encoding constants IDLE/ONES/ZERO/GAP (2'b00..2'b11)
  - default CNT_W
- One sub-module is natural: rls_down_counter (load, tick-gated decrement, is_one flag). It is instantiated for the run counter, and also for the gap counter under the macro.
- The FSM stays in the top module.

Test Plan:
- Reset mid-frame: run_len=5, assert reset after the 2nd one → bit_out=0 and busy=0 immediately. No frame_done. Next accept behaves normally.
- Single frame, bit_tick=1: run_len=3 accepted at edge E0 → bit_out 1,1,1,0 on the cycles after E0..E3. frame_done=1 only in the cycle after E4. busy returns low in that same cycle.
- Back-to-back, bit_tick=1, run_valid held high: run_len=2 then 1 → stream 1,1,0,1,0 with no idle bit. frame_done pulses twice.
- Zero length: run_len=0 → single 0 bit, one frame_done pulse, detector output stays 0.
- Tick gating: bit_tick high every 3rd cycle, run_len=2 → each bit held 3 cycles. frame_done is one cycle wide.
- RLS_IDLE_GAP_EN, GAP_LEN=2, bit_tick=1, run_valid held high: run_len=1 twice → 1,0,0,0,1,0. run_ready=0 during ZERO and the first GAP tick.
